sprite_mask_arbiter: RTL and testbench

Shares one synchronous single-port sprite-mask ROM between NUM_REQ pixel requesters (player, ghost and dot renderers).
- Round-robin arbitration; one ROM lookup per cycle.
- Each access returns 1 mask bit, tagged to its requester.
- Supports single-pixel requests and row bursts (x0 up to TILE_SIZE-1 on one row).
- Sits between the renderers and the mask store. The ROM holds all tile masks concatenated, each stored row-major.

---
 rtl/sprite_mask_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_sprite_mask_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_mask_arbiter.sv
// Round-robin arbiter sharing one single-port sprite-mask ROM between pixel requesters.
// Define SPRITE_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module sprite_mask_arbiter #(
    parameter int unsigned TILE_SIZE  = 16,
    parameter int unsigned NUM_IMAGES = 16,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned IMG_W      = 4,
    parameter int unsigned COORD_W    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_burst,
    input  logic [NUM_REQ*IMG_W-1:0]       req_img,
    input  logic [NUM_REQ*COORD_W-1:0]     req_x,
    input  logic [NUM_REQ*COORD_W-1:0]     req_y,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           rom_en,
    output logic [IMG_W+2*COORD_W-1:0]     rom_addr,
    input  logic                           rom_data,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic                           resp_pixel,
    output logic                           resp_last,
    output logic                           busy
);

    localparam int unsigned IdW = $clog2(NUM_REQ);
    localparam logic [COORD_W-1:0] XLast = COORD_W'(TILE_SIZE - 1);
    localparam logic [IMG_W:0] ImgLimit = (IMG_W+1)'(NUM_IMAGES);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e               state_q, state_d;
    logic [IMG_W-1:0]     img_q, img_d;
    logic [COORD_W-1:0]   y_q, y_d;
    logic [COORD_W-1:0]   cur_x_q, cur_x_d;
    logic [IdW-1:0]       id_q, id_d;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
    logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
`endif

    logic                 p1_valid_q, p1_valid_d;
    logic [IdW-1:0]       p1_id_q, p1_id_d;
    logic                 p1_last_q, p1_last_d;
    logic                 p1_oor_q, p1_oor_d;
    logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic                 resp_pixel_q, resp_pixel_d;
    logic                 resp_last_q, resp_last_d;

    logic                 grant_found;
    logic [IdW-1:0]       grant_id;
    logic [IMG_W-1:0]     g_img;
    logic [COORD_W-1:0]   g_x, g_y;
    logic                 g_burst;

    logic                 acc_issue, acc_last, acc_oor;
    logic [IMG_W-1:0]     acc_img;
    logic [COORD_W-1:0]   acc_y, acc_x;
    logic [IdW-1:0]       acc_id;

    // First valid requester in search order, then its payload.
    always_comb begin
        logic [IdW-1:0] idx;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef SPRITE_ARB_FIXED_PRIO_EN
            idx = IdW'(i);
`else
            idx = IdW'((32'(rr_ptr_q) + i) % NUM_REQ);
`endif
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
        g_img   = '0;
        g_x     = '0;
        g_y     = '0;
        g_burst = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant_id == IdW'(k)) begin
                g_img   = req_img[k*IMG_W +: IMG_W];
                g_x     = req_x[k*COORD_W +: COORD_W];
                g_y     = req_y[k*COORD_W +: COORD_W];
                g_burst = req_burst[k];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        img_d     = img_q;
        y_d       = y_q;
        cur_x_d   = cur_x_q;
        id_d      = id_q;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
        rr_ptr_d  = rr_ptr_q;
`endif
        req_ready = '0;
        acc_issue = 1'b0;
        acc_last  = 1'b0;
        acc_img   = img_q;
        acc_y     = y_q;
        acc_x     = cur_x_q;
        acc_id    = id_q;
        unique case (state_q)
            StIdle: begin
                if (grant_found && !rst) begin
                    req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
                    rr_ptr_d  = (grant_id == IdW'(NUM_REQ - 1)) ? '0 : grant_id + IdW'(1);
`endif
                    acc_issue = 1'b1;
                    acc_img   = g_img;
                    acc_y     = g_y;
                    acc_x     = g_x;
                    acc_id    = grant_id;
                    acc_last  = !g_burst || (g_x == XLast);
                    if (g_burst) begin
                        img_d   = g_img;
                        y_d     = g_y;
                        id_d    = grant_id;
                        cur_x_d = g_x + COORD_W'(1);
                        if (g_x != XLast) begin
                            state_d = StBurst;
                        end
                    end
                end
            end
            StBurst: begin
                acc_issue = !rst;
                acc_last  = (cur_x_q == XLast);
                cur_x_d   = cur_x_q + COORD_W'(1);
                if (cur_x_q == XLast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Out-of-range images are sequenced like any other but never touch the ROM.
    always_comb begin
        acc_oor  = ({1'b0, acc_img} >= ImgLimit);
        rom_en   = acc_issue && !acc_oor;
        rom_addr = rom_en ? {acc_img, acc_y, acc_x} : '0;
        busy     = (state_q == StBurst);

        p1_valid_d   = acc_issue;
        p1_id_d      = acc_id;
        p1_last_d    = acc_last;
        p1_oor_d     = acc_oor;
        resp_valid_d = p1_valid_q ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << p1_id_q) : '0;
        resp_pixel_d = p1_valid_q && !p1_oor_q && rom_data;
        resp_last_d  = p1_valid_q && p1_last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            img_q        <= '0;
            y_q          <= '0;
            cur_x_q      <= '0;
            id_q         <= '0;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= '0;
`endif
            p1_valid_q   <= 1'b0;
            p1_id_q      <= '0;
            p1_last_q    <= 1'b0;
            p1_oor_q     <= 1'b0;
            resp_valid_q <= '0;
            resp_pixel_q <= 1'b0;
            resp_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            img_q        <= img_d;
            y_q          <= y_d;
            cur_x_q      <= cur_x_d;
            id_q         <= id_d;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
            p1_valid_q   <= p1_valid_d;
            p1_id_q      <= p1_id_d;
            p1_last_q    <= p1_last_d;
            p1_oor_q     <= p1_oor_d;
            resp_valid_q <= resp_valid_d;
            resp_pixel_q <= resp_pixel_d;
            resp_last_q  <= resp_last_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_pixel = resp_pixel_q;
    assign resp_last  = resp_last_q;

endmodule

// File: tb/tb_sprite_mask_arbiter.sv
// Directed bench for sprite_mask_arbiter; NUM_IMAGES=12 so index 12 is out of range.
module tb_sprite_mask_arbiter;

    localparam int NR = 4;
    localparam int IW = 4;
    localparam int CW = 4;
    localparam int AW = IW + 2 * CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req_valid = '0;
    logic [NR-1:0] req_burst = '0;
    logic [NR*IW-1:0] req_img = '0;
    logic [NR*CW-1:0] req_x = '0;
    logic [NR*CW-1:0] req_y = '0;
    logic [NR-1:0] req_ready;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic          rom_data;
    logic [NR-1:0] resp_valid;
    logic          resp_pixel;
    logic          resp_last;
    logic          busy;

    logic rom_q = 1'b0;
    logic force1 = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // ROM content: parity of the address.
    always_ff @(posedge clk) if (rom_en) rom_q <= ^rom_addr;
    assign rom_data = force1 ? 1'b1 : rom_q;

    sprite_mask_arbiter #(
        .TILE_SIZE (16),
        .NUM_IMAGES(12),
        .NUM_REQ   (NR),
        .IMG_W     (IW),
        .COORD_W   (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_burst (req_burst),
        .req_img   (req_img),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .resp_valid(resp_valid),
        .resp_pixel(resp_pixel),
        .resp_last (resp_last),
        .busy      (busy)
    );

    function automatic logic [AW-1:0] mk_addr(input int img, input int y, input int x);
        logic [IW-1:0] i4;
        logic [CW-1:0] y4, x4;
        i4 = IW'(img);
        y4 = CW'(y);
        x4 = CW'(x);
        return {i4, y4, x4};
    endfunction

    task automatic set_req(input int k, input logic v, input logic b,
                           input int img, input int y, input int x);
        req_valid[k] = v;
        req_burst[k] = b;
        req_img[k*IW +: IW] = IW'(img);
        req_y[k*CW +: CW] = CW'(y);
        req_x[k*CW +: CW] = CW'(x);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        req_burst = '0;
        force1 = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [NR*2+AW+3:0] all_out;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            all_out = {req_ready, rom_en, rom_addr, resp_valid, resp_pixel, resp_last, busy};
            checks++;
            if (all_out !== '0) begin
                errors++;
                $display("FAIL idle_outputs c=%0d: got %h expected 0", c, all_out);
            end
            next_cycle();
        end
    endtask

    task automatic test_round_robin();
        int g, r;
        logic [NR-1:0] exp_rdy, exp_rv;
        logic [AW-1:0] a;
        do_reset();
        for (int k = 0; k < NR; k++) set_req(k, 1'b1, 1'b0, k + 1, k, 2 * k + 1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
`ifdef SPRITE_ARB_FIXED_PRIO_EN
            g = 0;
            r = 0;
`else
            g = c % NR;
            r = (c + NR - 2) % NR;
`endif
            exp_rdy = 4'b0001 << g;
            a = mk_addr(g + 1, g, 2 * g + 1);
            checks++;
            if (req_ready !== exp_rdy || rom_en !== 1'b1 || rom_addr !== a) begin
                errors++;
                $display("FAIL rr_grant c=%0d: got rdy=%b en=%b addr=%h expected rdy=%b en=1 addr=%h",
                         c, req_ready, rom_en, rom_addr, exp_rdy, a);
            end
            exp_rv = (c >= 2) ? (4'b0001 << r) : 4'b0000;
            a = mk_addr(r + 1, r, 2 * r + 1);
            checks++;
            if (resp_valid !== exp_rv ||
                (c >= 2 && (resp_last !== 1'b1 || resp_pixel !== ^a))) begin
                errors++;
                $display("FAIL rr_resp c=%0d: got v=%b last=%b pix=%b expected v=%b last=1 pix=%b",
                         c, resp_valid, resp_last, resp_pixel, exp_rv, ^a);
            end
            next_cycle();
        end
        req_valid = '0;
    endtask

    task automatic test_burst();
        logic [NR-1:0] exp_rdy, exp_rv;
        logic [AW-1:0] a;
        logic exp_busy, exp_en, exp_last, exp_pix;
        do_reset();
        set_req(2, 1'b1, 1'b1, 3, 5, 12);
        for (int c = 0; c < 7; c++) begin
            if (c == 1) begin
                req_valid[2] = 1'b0;
                set_req(0, 1'b1, 1'b0, 7, 1, 9);
            end
            if (c == 5) req_valid[0] = 1'b0;
            @(negedge clk);
            exp_busy = (c >= 1 && c <= 3);
            exp_en = (c <= 4);
            exp_rdy = (c == 0) ? 4'b0100 : (c == 4) ? 4'b0001 : 4'b0000;
            a = (c <= 3) ? mk_addr(3, 5, 12 + c) : (c == 4) ? mk_addr(7, 1, 9) : '0;
            checks++;
            if (req_ready !== exp_rdy || busy !== exp_busy || rom_en !== exp_en ||
                rom_addr !== a) begin
                errors++;
                $display("FAIL burst_issue c=%0d: got rdy=%b busy=%b en=%b addr=%h expected rdy=%b busy=%b en=%b addr=%h",
                         c, req_ready, busy, rom_en, rom_addr, exp_rdy, exp_busy, exp_en, a);
            end
            exp_rv = (c >= 2 && c <= 5) ? 4'b0100 : (c == 6) ? 4'b0001 : 4'b0000;
            exp_last = (c >= 5);
            exp_pix = (c >= 2 && c <= 5) ? ^mk_addr(3, 5, 10 + c) :
                      (c == 6) ? ^mk_addr(7, 1, 9) : 1'b0;
            checks++;
            if (resp_valid !== exp_rv || resp_last !== exp_last || resp_pixel !== exp_pix) begin
                errors++;
                $display("FAIL burst_resp c=%0d: got v=%b last=%b pix=%b expected v=%b last=%b pix=%b",
                         c, resp_valid, resp_last, resp_pixel, exp_rv, exp_last, exp_pix);
            end
            next_cycle();
        end
        req_valid = '0;
    endtask

    task automatic test_out_of_range();
        logic [NR-1:0] exp_rv;
        logic exp_pix, exp_en;
        do_reset();
        force1 = 1'b1;
        set_req(1, 1'b1, 1'b0, 12, 3, 4);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) set_req(1, 1'b1, 1'b0, 2, 3, 4);
            if (c == 2) req_valid = '0;
            @(negedge clk);
            exp_en = (c == 1);
            if (c <= 1) begin
                checks++;
                if (req_ready !== 4'b0010 || rom_en !== exp_en ||
                    (c == 1 && rom_addr !== mk_addr(2, 3, 4))) begin
                    errors++;
                    $display("FAIL oor_issue c=%0d: got rdy=%b en=%b addr=%h expected rdy=0010 en=%b",
                             c, req_ready, rom_en, rom_addr, exp_en);
                end
            end
            exp_rv = (c >= 2) ? 4'b0010 : 4'b0000;
            exp_pix = (c == 3);
            checks++;
            if (resp_valid !== exp_rv || resp_pixel !== exp_pix ||
                (c >= 2 && resp_last !== 1'b1)) begin
                errors++;
                $display("FAIL oor_resp c=%0d: got v=%b pix=%b last=%b expected v=%b pix=%b",
                         c, resp_valid, resp_pixel, resp_last, exp_rv, exp_pix);
            end
            next_cycle();
        end
        force1 = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        logic [NR-1:0] exp_rv, exp_rdy;
        logic exp_pix;
        do_reset();
        set_req(3, 1'b1, 1'b1, 1, 2, 0);
        for (int c = 0; c < 10; c++) begin
            if (c == 1) req_valid[3] = 1'b0;
            if (c == 5) begin
                rst = 1'b1;
                set_req(0, 1'b1, 1'b0, 4, 4, 4);
                set_req(3, 1'b1, 1'b0, 5, 5, 5);
            end
            if (c == 6) rst = 1'b0;
            if (c == 7) req_valid[0] = 1'b0;
            if (c == 8) req_valid[3] = 1'b0;
            @(negedge clk);
            if (c <= 4) begin
                checks++;
                if (rom_addr !== mk_addr(1, 2, c) || busy !== (c > 0)) begin
                    errors++;
                    $display("FAIL mid_issue c=%0d: got addr=%h busy=%b expected addr=%h busy=%b",
                             c, rom_addr, busy, mk_addr(1, 2, c), (c > 0));
                end
            end
            if (c >= 5 && c <= 7) begin
                exp_rdy = (c == 6) ? 4'b0001 : (c == 7) ? 4'b1000 : 4'b0000;
                checks++;
                if (req_ready !== exp_rdy || (c >= 6 && busy !== 1'b0)) begin
                    errors++;
                    $display("FAIL mid_grant c=%0d: got rdy=%b busy=%b expected rdy=%b busy=0",
                             c, req_ready, busy, exp_rdy);
                end
            end
            exp_rv = (c >= 2 && c <= 5) ? 4'b1000 : (c == 8) ? 4'b0001 :
                     (c == 9) ? 4'b1000 : 4'b0000;
            exp_pix = (c >= 2 && c <= 5) ? ^mk_addr(1, 2, c - 2) :
                      (c == 8) ? ^mk_addr(4, 4, 4) : (c == 9) ? ^mk_addr(5, 5, 5) : 1'b0;
            checks++;
            if (resp_valid !== exp_rv || resp_pixel !== exp_pix) begin
                errors++;
                $display("FAIL mid_resp c=%0d: got v=%b pix=%b expected v=%b pix=%b",
                         c, resp_valid, resp_pixel, exp_rv, exp_pix);
            end
            next_cycle();
        end
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_fixed_prio();
        logic [NR-1:0] exp_rdy;
        do_reset();
        set_req(1, 1'b1, 1'b0, 1, 1, 1);
        set_req(3, 1'b1, 1'b0, 2, 2, 2);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
`ifdef SPRITE_ARB_FIXED_PRIO_EN
            exp_rdy = 4'b0010;
`else
            exp_rdy = (c % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL prio_grant c=%0d: got %b expected %b", c, req_ready, exp_rdy);
            end
            next_cycle();
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst();
        test_out_of_range();
        test_reset_mid_burst();
        test_fixed_prio();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
